// File: rtl/mbist_pkg.sv
// mbist_pkg - shared definitions for the March C- memory BIST controller.
//
// Contents:
//   state_e      sequencer states (IDLE, SETUP, RUN, DRAIN, DONE)
//   op_e         memory operation type (RD, WR)
//   M0..M5       March element indices
//   elem_*()     per-element lookup: address direction, whether the element
//                reads and/or writes, and the data polarity of each.
//
// March C- table (D = all-0 background, ~D = all-1):
//   M0 up   w0      M1 up   r0,w1   M2 up   r1,w0
//   M3 down r0,w1   M4 down r1,w0   M5 up   r0
package mbist_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    RUN   = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_e;

  typedef enum logic {
    RD = 1'b0,
    WR = 1'b1
  } op_e;

  localparam logic [2:0] M0 = 3'd0;
  localparam logic [2:0] M1 = 3'd1;
  localparam logic [2:0] M2 = 3'd2;
  localparam logic [2:0] M3 = 3'd3;
  localparam logic [2:0] M4 = 3'd4;
  localparam logic [2:0] M5 = 3'd5;

  // 1 = element walks the address space from the top down.
  function automatic logic elem_down(input logic [2:0] elem);
    logic r;
    case (elem)
      M3, M4:  r = 1'b1;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  // 1 = element performs a read at each address.
  function automatic logic elem_has_rd(input logic [2:0] elem);
    logic r;
    case (elem)
      M1, M2, M3, M4, M5: r = 1'b1;
      default:            r = 1'b0;
    endcase
    return r;
  endfunction

  // 1 = element performs a write at each address.
  function automatic logic elem_has_wr(input logic [2:0] elem);
    logic r;
    case (elem)
      M0, M1, M2, M3, M4: r = 1'b1;
      default:            r = 1'b0;
    endcase
    return r;
  endfunction

  // Polarity every read of the element expects (0 = D, 1 = ~D).
  function automatic logic elem_rd_pol(input logic [2:0] elem);
    logic r;
    case (elem)
      M2, M4:  r = 1'b1;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  // Polarity the element writes (0 = D, 1 = ~D); read-only elements use 0.
  function automatic logic elem_wr_pol(input logic [2:0] elem);
    logic r;
    case (elem)
      M1, M3:  r = 1'b1;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mbist_cmp.sv
// mbist_cmp - read-data compare pipeline for the March C- BIST controller.
//
// A read issued on the memory pins at edge t is pushed here at the same edge;
// the memory returns its data two cycles later, so the entry is compared
// against rdata at edge t+2 after travelling through two register stages.
//
// Ports:
//   clk, rst_n   clock, synchronous active-low reset (clears valids and results)
//   clr          clear fail counter and first-fail capture (start of a run)
//   push         a compared read is issued on this edge
//   expected     expected read data for the pushed read
//   addr, elem   address and March element of the pushed read
//   rdata        memory read data
//   fail_cnt     saturating miscompare count
//   fail_addr    address of the first miscompare
//   fail_elem    element of the first miscompare
//   fail_data    actual XOR expected at the first miscompare
module mbist_cmp #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned CNT_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] expected,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [2:0]            elem,
  input  logic [DATA_WIDTH-1:0] rdata,
  output logic [CNT_WIDTH-1:0]  fail_cnt,
  output logic [ADDR_WIDTH-1:0] fail_addr,
  output logic [2:0]            fail_elem,
  output logic [DATA_WIDTH-1:0] fail_data
);

  localparam logic [CNT_WIDTH-1:0] CNT_ZERO = {CNT_WIDTH{1'b0}};
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CNT_WIDTH-1:0] CNT_MAX  = {CNT_WIDTH{1'b1}};

  logic                  s1_vld_r;
  logic [DATA_WIDTH-1:0] s1_exp_r;
  logic [ADDR_WIDTH-1:0] s1_addr_r;
  logic [2:0]            s1_elem_r;
  logic                  s2_vld_r;
  logic [DATA_WIDTH-1:0] s2_exp_r;
  logic [ADDR_WIDTH-1:0] s2_addr_r;
  logic [2:0]            s2_elem_r;

  logic [CNT_WIDTH-1:0]  fail_cnt_r;
  logic [ADDR_WIDTH-1:0] fail_addr_r;
  logic [2:0]            fail_elem_r;
  logic [DATA_WIDTH-1:0] fail_data_r;

  logic                  miss_s;
  logic [DATA_WIDTH-1:0] diff_s;

  // Miscompare detect at the end of the pipeline.
  always_comb begin
    diff_s = rdata ^ s2_exp_r;
    if (s2_vld_r && (diff_s != {DATA_WIDTH{1'b0}})) begin
      miss_s = 1'b1;
    end else begin
      miss_s = 1'b0;
    end
  end

  // Two-stage expected/valid pipeline aligned with the memory read latency.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_vld_r  <= 1'b0;
      s1_exp_r  <= {DATA_WIDTH{1'b0}};
      s1_addr_r <= {ADDR_WIDTH{1'b0}};
      s1_elem_r <= 3'd0;
      s2_vld_r  <= 1'b0;
      s2_exp_r  <= {DATA_WIDTH{1'b0}};
      s2_addr_r <= {ADDR_WIDTH{1'b0}};
      s2_elem_r <= 3'd0;
    end else begin
      s1_vld_r  <= push;
      s1_exp_r  <= expected;
      s1_addr_r <= addr;
      s1_elem_r <= elem;
      s2_vld_r  <= s1_vld_r;
      s2_exp_r  <= s1_exp_r;
      s2_addr_r <= s1_addr_r;
      s2_elem_r <= s1_elem_r;
    end
  end

  // Saturating fail counter and first-fail diagnostic capture.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fail_cnt_r  <= CNT_ZERO;
      fail_addr_r <= {ADDR_WIDTH{1'b0}};
      fail_elem_r <= 3'd0;
      fail_data_r <= {DATA_WIDTH{1'b0}};
    end else if (clr) begin
      fail_cnt_r  <= CNT_ZERO;
      fail_addr_r <= {ADDR_WIDTH{1'b0}};
      fail_elem_r <= 3'd0;
      fail_data_r <= {DATA_WIDTH{1'b0}};
    end else if (miss_s) begin
      if (fail_cnt_r != CNT_MAX) begin
        fail_cnt_r <= fail_cnt_r + CNT_ONE;
      end else begin
        fail_cnt_r <= fail_cnt_r;
      end
      // Only the first miscompare of a run is recorded.
      if (fail_cnt_r == CNT_ZERO) begin
        fail_addr_r <= s2_addr_r;
        fail_elem_r <= s2_elem_r;
        fail_data_r <= diff_s;
      end else begin
        fail_addr_r <= fail_addr_r;
        fail_elem_r <= fail_elem_r;
        fail_data_r <= fail_data_r;
      end
    end else begin
      fail_cnt_r  <= fail_cnt_r;
      fail_addr_r <= fail_addr_r;
      fail_elem_r <= fail_elem_r;
      fail_data_r <= fail_data_r;
    end
  end

  assign fail_cnt  = fail_cnt_r;
  assign fail_addr = fail_addr_r;
  assign fail_elem = fail_elem_r;
  assign fail_data = fail_data_r;

endmodule

// File: rtl/mbist_march_ctrl.sv
// mbist_march_ctrl - March C- memory BIST sequencer for a single-port array.
//
// Runs M0..M5 over addresses 0..CAPACITY, one memory operation per cycle,
// with a one-cycle SETUP (dummy read, write data preloaded) before every
// element and a two-cycle DRAIN at the end to flush the compare pipeline.
// Run length from the start-sampling edge to done is 10*N+8 cycles.
//
// Ports:
//   clk, rst_n      clock, synchronous active-low reset
//   start           run request, honoured only in IDLE or DONE
//   busy            run in progress (SETUP/RUN/DRAIN)
//   done            level, high in DONE
//   pass            valid with done, 1 = no miscompare
//   mem_write_read  memory op, 1 = write, 0 = read
//   mem_address     memory address
//   mem_wdata       memory write data (held for the whole element)
//   mem_rdata       memory read data, 2 cycles after the read
//   fail_cnt        saturating miscompare count
//   fail_addr/elem/data  first-miscompare diagnostics
module mbist_march_ctrl #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned CAPACITY   = 15,
  parameter int unsigned CNT_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic                  mem_write_read,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic [CNT_WIDTH-1:0]  fail_cnt,
  output logic [ADDR_WIDTH-1:0] fail_addr,
  output logic [2:0]            fail_elem,
  output logic [DATA_WIDTH-1:0] fail_data
);

  import mbist_pkg::*;

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(CAPACITY);
  localparam logic [ADDR_WIDTH-1:0] ZERO_ADDR = {ADDR_WIDTH{1'b0}};
  localparam logic [ADDR_WIDTH-1:0] ONE_ADDR  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  state_e                state_r;
  logic [2:0]            elem_r;
  logic [ADDR_WIDTH-1:0] addr_r;
  op_e                   op_r;
  logic [DATA_WIDTH-1:0] wdata_r;
  logic                  drain_r;
  logic                  busy_r;
  logic                  done_r;
  logic                  pass_r;

  state_e                state_nxt_s;
  logic [2:0]            elem_nxt_s;
  logic [ADDR_WIDTH-1:0] addr_nxt_s;
  op_e                   op_nxt_s;
  logic [DATA_WIDTH-1:0] wdata_nxt_s;
  logic                  drain_nxt_s;
  logic                  clr_s;

  logic [2:0]            elem_inc_s;
  op_e                   first_op_s;
  logic                  last_op_s;
  logic                  last_addr_hit_s;

  logic                  push_s;
  logic [DATA_WIDTH-1:0] exp_s;
  logic                  busy_nxt_s;
  logic                  done_nxt_s;
  logic                  pass_nxt_s;
  logic [CNT_WIDTH-1:0]  fail_cnt_s;

  // Per-element decode of the current element and address position.
  always_comb begin
    elem_inc_s = elem_r + 3'd1;
    if (elem_has_rd(elem_r)) begin
      first_op_s = RD;
    end else begin
      first_op_s = WR;
    end
    // A read is the last op at an address only in read-only elements.
    if ((op_r == WR) || !elem_has_wr(elem_r)) begin
      last_op_s = 1'b1;
    end else begin
      last_op_s = 1'b0;
    end
    // Terminal address depends on the walking direction; never wrap.
    if (elem_down(elem_r)) begin
      last_addr_hit_s = (addr_r == ZERO_ADDR);
    end else begin
      last_addr_hit_s = (addr_r == LAST_ADDR);
    end
  end

  // Next state, next memory operation and run-start clear.
  always_comb begin
    state_nxt_s = state_r;
    elem_nxt_s  = elem_r;
    addr_nxt_s  = addr_r;
    op_nxt_s    = op_r;
    wdata_nxt_s = wdata_r;
    drain_nxt_s = drain_r;
    clr_s       = 1'b0;
    case (state_r)
      IDLE, DONE: begin
        if (start) begin
          state_nxt_s = SETUP;
          elem_nxt_s  = M0;
          addr_nxt_s  = elem_down(M0) ? LAST_ADDR : ZERO_ADDR;
          op_nxt_s    = RD;
          wdata_nxt_s = {DATA_WIDTH{elem_wr_pol(M0)}};
          drain_nxt_s = 1'b0;
          clr_s       = 1'b1;
        end else begin
          op_nxt_s = RD;
        end
      end
      SETUP: begin
        state_nxt_s = RUN;
        op_nxt_s    = first_op_s;
      end
      RUN: begin
        if (last_op_s) begin
          if (last_addr_hit_s) begin
            if (elem_r == M5) begin
              state_nxt_s = DRAIN;
              op_nxt_s    = RD;
              drain_nxt_s = 1'b0;
            end else begin
              // Next element: SETUP presents its first address and preloads
              // its write value so the first write sees stable data.
              state_nxt_s = SETUP;
              elem_nxt_s  = elem_inc_s;
              addr_nxt_s  = elem_down(elem_inc_s) ? LAST_ADDR : ZERO_ADDR;
              op_nxt_s    = RD;
              wdata_nxt_s = {DATA_WIDTH{elem_wr_pol(elem_inc_s)}};
            end
          end else begin
            if (elem_down(elem_r)) begin
              addr_nxt_s = addr_r - ONE_ADDR;
            end else begin
              addr_nxt_s = addr_r + ONE_ADDR;
            end
            op_nxt_s = first_op_s;
          end
        end else begin
          op_nxt_s = WR;
        end
      end
      DRAIN: begin
        if (drain_r) begin
          state_nxt_s = DONE;
        end else begin
          drain_nxt_s = 1'b1;
        end
      end
      default: begin
        state_nxt_s = IDLE;
        op_nxt_s    = RD;
      end
    endcase
  end

  // Status outputs and compare-pipeline push for the op issued next edge.
  always_comb begin
    busy_nxt_s = (state_nxt_s == SETUP) || (state_nxt_s == RUN) ||
                 (state_nxt_s == DRAIN);
    done_nxt_s = (state_nxt_s == DONE);
    if (done_nxt_s && (fail_cnt_s == {CNT_WIDTH{1'b0}})) begin
      pass_nxt_s = 1'b1;
    end else begin
      pass_nxt_s = 1'b0;
    end
    // SETUP dummy reads are never pushed, only RUN reads.
    if ((state_nxt_s == RUN) && (op_nxt_s == RD)) begin
      push_s = 1'b1;
    end else begin
      push_s = 1'b0;
    end
    exp_s = {DATA_WIDTH{elem_rd_pol(elem_nxt_s)}};
  end

  // Sequencer state and registered memory/status outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= IDLE;
      elem_r  <= 3'd0;
      addr_r  <= ZERO_ADDR;
      op_r    <= RD;
      wdata_r <= {DATA_WIDTH{1'b0}};
      drain_r <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      pass_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      elem_r  <= elem_nxt_s;
      addr_r  <= addr_nxt_s;
      op_r    <= op_nxt_s;
      wdata_r <= wdata_nxt_s;
      drain_r <= drain_nxt_s;
      busy_r  <= busy_nxt_s;
      done_r  <= done_nxt_s;
      pass_r  <= pass_nxt_s;
    end
  end

  mbist_cmp #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .CNT_WIDTH  (CNT_WIDTH)
  ) u_cmp (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (clr_s),
    .push      (push_s),
    .expected  (exp_s),
    .addr      (addr_nxt_s),
    .elem      (elem_nxt_s),
    .rdata     (mem_rdata),
    .fail_cnt  (fail_cnt_s),
    .fail_addr (fail_addr),
    .fail_elem (fail_elem),
    .fail_data (fail_data)
  );

  assign busy           = busy_r;
  assign done           = done_r;
  assign pass           = pass_r;
  assign mem_write_read = (op_r == WR);
  assign mem_address    = addr_r;
  assign mem_wdata      = wdata_r;
  assign fail_cnt       = fail_cnt_s;

endmodule

// File: tb/tb_mbist_march_ctrl.sv
// tb_mbist_march_ctrl - self-checking bench for mbist_march_ctrl.
//
// A behavioural memory with injectable faults sits on the memory pins. Each
// run's expected verdict, diagnostics and final memory image come from a
// March C- reference walk over a copy of the memory using the same fault
// rules; the bench also measures latency and watches the write-data protocol.
module tb_mbist_march_ctrl;

  localparam int DW  = 8;
  localparam int AW  = 4;
  localparam int CAP = 15;
  localparam int CW  = 8;
  localparam int N   = CAP + 1;
  localparam int LAT = 10 * N + 8;

  localparam int F_NONE    = 0;
  localparam int F_TF_FALL = 1;
  localparam int F_TF_RISE = 2;
  localparam int F_SA1     = 3;
  localparam int F_SA0     = 4;
  localparam int F_INV     = 5;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic          busy, done, pass;
  logic          mem_write_read;
  logic [AW-1:0] mem_address;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic [CW-1:0] fail_cnt;
  logic [AW-1:0] fail_addr;
  logic [2:0]    fail_elem;
  logic [DW-1:0] fail_data;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mbist_march_ctrl #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .CAPACITY   (CAP),
    .CNT_WIDTH  (CW)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .busy           (busy),
    .done           (done),
    .pass           (pass),
    .mem_write_read (mem_write_read),
    .mem_address    (mem_address),
    .mem_wdata      (mem_wdata),
    .mem_rdata      (mem_rdata),
    .fail_cnt       (fail_cnt),
    .fail_addr      (fail_addr),
    .fail_elem      (fail_elem),
    .fail_data      (fail_data)
  );

  // ---------------- fault model and memory ----------------
  int f_kind = F_NONE;
  int f_addr = 0;
  int f_bit  = 0;

  function automatic logic [DW-1:0] flt_write(input logic [DW-1:0] old_v,
                                              input logic [DW-1:0] new_v,
                                              input int a);
    logic [DW-1:0] r;
    r = new_v;
    if (a == f_addr) begin
      case (f_kind)
        F_TF_FALL: if (old_v[f_bit] && !new_v[f_bit]) r[f_bit] = 1'b1;
        F_TF_RISE: if (!old_v[f_bit] && new_v[f_bit]) r[f_bit] = 1'b0;
        F_SA1:     r[f_bit] = 1'b1;
        F_SA0:     r[f_bit] = 1'b0;
        default:   r = new_v;
      endcase
    end
    return r;
  endfunction

  function automatic logic [DW-1:0] flt_read(input logic [DW-1:0] v);
    return (f_kind == F_INV) ? ~v : v;
  endfunction

  logic [DW-1:0] mem [N];
  logic [DW-1:0] wdata_q;
  logic          mem_init_r = 1'b0;

  // Memory: write data registered one cycle ahead, read data 1 cycle after
  // sampling the address (so 2 cycles after the DUT issues it).
  always @(posedge clk) begin
    if (!mem_init_r) begin
      for (int i = 0; i < N; i++) mem[i] <= DW'($urandom);
      mem_init_r <= 1'b1;
    end else if (mem_write_read === 1'b1) begin
      mem[mem_address] <= flt_write(mem[mem_address], wdata_q, int'(mem_address));
    end
    wdata_q   <= mem_wdata;
    mem_rdata <= flt_read(mem[mem_address]);
  end

  // Protocol monitor: write cycles counted, wdata must match previous cycle.
  int            wr_tot    = 0;
  int            proto_tot = 0;
  logic [DW-1:0] prev_wdata = '0;
  always @(negedge clk) begin
    if (mem_write_read === 1'b1) begin
      wr_tot <= wr_tot + 1;
      if (mem_wdata !== prev_wdata) proto_tot <= proto_tot + 1;
    end
    prev_wdata <= mem_wdata;
  end

  // ---------------- reference model ----------------
  bit el_down [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
  bit el_rd   [6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
  bit el_rpol [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
  bit el_wr   [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
  bit el_wpol [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};

  int            exp_cnt, exp_addr, exp_elem;
  logic [DW-1:0] exp_data;
  logic [DW-1:0] exp_img [N];

  task automatic model_run();
    logic [DW-1:0] m [N];
    logic [DW-1:0] v, ev;
    int a;
    for (int i = 0; i < N; i++) m[i] = mem[i];
    exp_cnt = 0; exp_addr = 0; exp_elem = 0; exp_data = '0;
    for (int e = 0; e < 6; e++) begin
      for (int i = 0; i < N; i++) begin
        a = el_down[e] ? (N - 1 - i) : i;
        if (el_rd[e]) begin
          ev = {DW{el_rpol[e]}};
          v  = flt_read(m[a]);
          if (v !== ev) begin
            if (exp_cnt == 0) begin
              exp_addr = a; exp_elem = e; exp_data = v ^ ev;
            end
            if (exp_cnt < (1 << CW) - 1) exp_cnt++;
          end
        end
        if (el_wr[e]) m[a] = flt_write(m[a], {DW{el_wpol[e]}}, a);
      end
    end
    for (int i = 0; i < N; i++) exp_img[i] = m[i];
  endtask

  // ---------------- checking ----------------
  task automatic check_val(input string tag, input logic [63:0] obs,
                           input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One complete run, entered at a negedge; start may already be high.
  task automatic run_once(input string tag, input bit hold);
    int wr0, pe0, cyc, gaps, bad_words;
    start = 1'b1;
    model_run();
    wr0 = wr_tot;
    pe0 = proto_tot;
    @(negedge clk);
    if (!hold) start = 1'b0;
    check_val({tag, "_busy_rise"}, busy, 1);
    cyc  = 0;
    gaps = 0;
    while (done !== 1'b1 && cyc < LAT + 40) begin
      @(negedge clk);
      cyc++;
      if (done !== 1'b1 && busy !== 1'b1) gaps++;
    end
    check_val({tag, "_latency"}, cyc, LAT);
    check_val({tag, "_done"}, done, 1);
    check_val({tag, "_busy_low"}, busy, 0);
    check_val({tag, "_busy_gaps"}, gaps, 0);
    check_val({tag, "_pass"}, pass, (exp_cnt == 0));
    check_val({tag, "_fail_cnt"}, fail_cnt, exp_cnt);
    check_val({tag, "_fail_addr"}, fail_addr, exp_addr);
    check_val({tag, "_fail_elem"}, fail_elem, exp_elem);
    check_val({tag, "_fail_data"}, fail_data, exp_data);
    check_val({tag, "_writes"}, wr_tot - wr0, 5 * N);
    check_val({tag, "_wdata_proto"}, proto_tot - pe0, 0);
    bad_words = 0;
    for (int i = 0; i < N; i++) if (mem[i] !== exp_img[i]) bad_words++;
    check_val({tag, "_mem_image"}, bad_words, 0);
  endtask

  task automatic check_all_zero(input string tag);
    check_val(tag, {busy, done, pass, mem_write_read, mem_address, mem_wdata,
                    fail_cnt, fail_addr, fail_elem, fail_data}, 64'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("reset_outputs");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Clean memory.
    f_kind = F_NONE;
    run_once("clean", 1'b0);
    check_val("clean_const_pass", pass, 1);

    // Bit-4 falling transition fault at address 5 (memory is all-0 here).
    repeat (3) @(negedge clk);
    f_kind = F_TF_FALL; f_addr = 5; f_bit = 4;
    run_once("tf", 1'b0);
    check_val("tf_const_cnt", fail_cnt, 2);
    check_val("tf_const_elem", fail_elem, 3);
    check_val("tf_const_addr", fail_addr, 5);
    check_val("tf_const_data", fail_data, 8'h10);

    // Stuck-at-1 bit 0 at address 0, start held through two runs.
    repeat (2) @(negedge clk);
    f_kind = F_SA1; f_addr = 0; f_bit = 0;
    run_once("sa1_hold", 1'b1);
    check_val("sa1_const_cnt", fail_cnt, 3);
    check_val("sa1_const_elem", fail_elem, 1);
    check_val("sa1_const_addr", fail_addr, 0);
    check_val("sa1_const_data", fail_data, 8'h01);
    f_kind = F_NONE;
    run_once("rerun_hold", 1'b1);
    start = 1'b0;
    repeat (2) @(negedge clk);

    // Every read miscompares; SETUP dummy reads must not count.
    f_kind = F_INV;
    run_once("allfail", 1'b0);
    check_val("allfail_const_cnt", fail_cnt, 5 * N);

    // Reset in the middle of M2, then a clean run.
    repeat (2) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3 * N + 10) @(negedge clk);
    check_val("mid_busy", busy, 1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check_all_zero("midreset_outputs");
    repeat (4) @(negedge clk);
    check_val("midreset_pipe_flushed", fail_cnt, 0);
    check_val("midreset_idle", {busy, done}, 0);
    f_kind = F_NONE;
    run_once("after_reset", 1'b0);

    // Randomised faults and idle gaps.
    for (int k = 0; k < 6; k++) begin
      repeat ($urandom_range(1, 6)) @(negedge clk);
      f_kind = $urandom_range(0, 5);
      f_addr = $urandom_range(0, N - 1);
      f_bit  = $urandom_range(0, DW - 1);
      run_once($sformatf("rnd%0d", k), 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
